// File: rtl/tcm_arb_pkg.sv
// Shared types for the single-port TCM arbiter: grant encoding and response register layout.
package tcm_arb_pkg;

    localparam int TCM_TAG_W = 11;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_I,
        GNT_D_MEM,
        GNT_D_MAINT
    } tcm_gnt_e;

    typedef struct packed {
        logic                 valid;
        logic                 ack;
        logic                 is_load;
        logic                 err;
        logic [TCM_TAG_W-1:0] tag;
    } tcm_resp_t;

endpackage

// File: rtl/tcm_arb_starve_ctr.sv
// Saturating count of consecutive cycles the fetch port has been requesting without a grant.
module tcm_arb_starve_ctr #(
    parameter int STARVE_MAX = 4,
    parameter int CW         = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic          gnt_i,
    output logic [CW-1:0] count_o,
    output logic          force_o
);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (req_i && !gnt_i) begin
            if (count_q != CW'(STARVE_MAX))
                count_q <= count_q + CW'(1);
        end else begin
            count_q <= '0;
        end
    end

    assign count_o = count_q;
    assign force_o = (count_q == CW'(STARVE_MAX));

endmodule

// File: rtl/tcm_port_arb.sv
// Arbitrates core fetch and data ports onto one single-ported SRAM with one-cycle responses.
// Optional TCM_ARB_RANGE_CHK_EN: out-of-window accesses skip the SRAM and respond with error.
module tcm_port_arb
    import tcm_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          AW         = 14,
    parameter int          STARVE_MAX = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 mem_i_rd_i,
    input  logic                 mem_i_flush_i,
    input  logic                 mem_i_invalidate_i,
    input  logic [31:0]          mem_i_pc_i,
    output logic                 mem_i_accept_o,
    output logic                 mem_i_valid_o,
    output logic                 mem_i_error_o,
    output logic [31:0]          mem_i_inst_o,
    input  logic [31:0]          mem_d_addr_i,
    input  logic [31:0]          mem_d_data_wr_i,
    input  logic                 mem_d_rd_i,
    input  logic [3:0]           mem_d_wr_i,
    input  logic                 mem_d_cacheable_i,
    input  logic [TCM_TAG_W-1:0] mem_d_req_tag_i,
    input  logic                 mem_d_invalidate_i,
    input  logic                 mem_d_writeback_i,
    input  logic                 mem_d_flush_i,
    output logic                 mem_d_accept_o,
    output logic                 mem_d_ack_o,
    output logic                 mem_d_error_o,
    output logic [31:0]          mem_d_data_rd_o,
    output logic [TCM_TAG_W-1:0] mem_d_resp_tag_o,
    output logic                 ram_en_o,
    output logic [3:0]           ram_wr_o,
    output logic [AW-1:0]        ram_addr_o,
    output logic [31:0]          ram_wdata_o,
    input  logic [31:0]          ram_rdata_i
);

    localparam int SCW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    tcm_gnt_e  gnt;
    tcm_resp_t resp_d, resp_q;
    logic      d_mem_req, d_maint_req, d_req;
    logic      starve_force;
    logic      i_in_win, d_in_win;
    logic [SCW-1:0] starve_q;

`ifdef TCM_ARB_RANGE_CHK_EN
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd1 << (AW + 2));

    function automatic logic in_win(input logic [31:0] a);
        return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
    endfunction

    assign i_in_win = in_win(mem_i_pc_i);
    assign d_in_win = in_win(mem_d_addr_i);
`else
    // Without the check only the word-index bits are decoded, so the window aliases.
    assign i_in_win = 1'b1;
    assign d_in_win = 1'b1;
`endif

    logic unused_ok;
    assign unused_ok = ^{mem_d_cacheable_i, mem_i_flush_i, mem_i_invalidate_i,
                         mem_i_pc_i[31:AW+2], mem_i_pc_i[1:0],
                         mem_d_addr_i[31:AW+2], mem_d_addr_i[1:0], BASE_ADDR};

    assign d_mem_req   = mem_d_rd_i || (mem_d_wr_i != 4'b0000);
    assign d_maint_req = mem_d_invalidate_i || mem_d_writeback_i || mem_d_flush_i;
    assign d_req       = d_mem_req || d_maint_req;

    tcm_arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX),
        .CW        (SCW)
    ) u_starve (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (mem_i_rd_i),
        .gnt_i  (gnt == GNT_I),
        .count_o(starve_q),
        .force_o(starve_force)
    );

    // Data normally wins; a fetch that has lost STARVE_MAX cycles in a row takes the slot.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst_i) begin
            if (mem_i_rd_i && (starve_force || !d_req))
                gnt = GNT_I;
            else if (d_mem_req)
                gnt = GNT_D_MEM;
            else if (d_maint_req)
                gnt = GNT_D_MAINT;
        end
    end

    always_comb begin
        ram_en_o    = 1'b0;
        ram_wr_o    = 4'b0000;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        resp_d      = '0;
        case (gnt)
            GNT_I: begin
                ram_en_o     = i_in_win;
                ram_addr_o   = i_in_win ? mem_i_pc_i[AW+1:2] : '0;
                resp_d.valid = 1'b1;
                resp_d.err   = !i_in_win;
            end
            GNT_D_MEM: begin
                ram_en_o       = d_in_win;
                ram_wr_o       = d_in_win ? mem_d_wr_i : 4'b0000;
                ram_addr_o     = d_in_win ? mem_d_addr_i[AW+1:2] : '0;
                ram_wdata_o    = d_in_win ? mem_d_data_wr_i : '0;
                resp_d.ack     = 1'b1;
                resp_d.is_load = (mem_d_wr_i == 4'b0000);
                resp_d.err     = !d_in_win;
                resp_d.tag     = mem_d_req_tag_i;
            end
            GNT_D_MAINT: begin
                resp_d.ack = 1'b1;
                resp_d.tag = mem_d_req_tag_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            resp_q <= '0;
        else
            resp_q <= resp_d;
    end

    assign mem_i_accept_o = (gnt == GNT_I);
    assign mem_d_accept_o = (gnt == GNT_D_MEM) || (gnt == GNT_D_MAINT);

    assign mem_i_valid_o    = resp_q.valid;
    assign mem_i_error_o    = resp_q.valid && resp_q.err;
    assign mem_i_inst_o     = (resp_q.valid && !resp_q.err) ? ram_rdata_i : '0;

    assign mem_d_ack_o      = resp_q.ack;
    assign mem_d_error_o    = resp_q.ack && resp_q.err;
    assign mem_d_data_rd_o  = (resp_q.ack && resp_q.is_load && !resp_q.err) ? ram_rdata_i : '0;
    assign mem_d_resp_tag_o = resp_q.ack ? resp_q.tag : '0;

endmodule

// File: tb/tb_tcm_port_arb.sv
// Directed bench for tcm_port_arb with a behavioural one-cycle-latency SRAM.
module tb_tcm_port_arb;

    localparam int AW = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i;
    logic [31:0] mem_i_pc_i;
    logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
    logic [31:0] mem_i_inst_o;
    logic [31:0] mem_d_addr_i, mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic        mem_d_cacheable_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i;
    logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
    logic [31:0] mem_d_data_rd_o;
    logic [10:0] mem_d_resp_tag_o;
    logic        ram_en_o;
    logic [3:0]  ram_wr_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0] ram_wdata_o, ram_rdata_i;

    logic [31:0] sram [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tcm_port_arb #(.BASE_ADDR(32'h8000_0000), .AW(AW), .STARVE_MAX(4)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .mem_i_rd_i(mem_i_rd_i), .mem_i_flush_i(mem_i_flush_i),
        .mem_i_invalidate_i(mem_i_invalidate_i), .mem_i_pc_i(mem_i_pc_i),
        .mem_i_accept_o(mem_i_accept_o), .mem_i_valid_o(mem_i_valid_o),
        .mem_i_error_o(mem_i_error_o), .mem_i_inst_o(mem_i_inst_o),
        .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
        .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i),
        .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_req_tag_i(mem_d_req_tag_i),
        .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
        .mem_d_flush_i(mem_d_flush_i), .mem_d_accept_o(mem_d_accept_o),
        .mem_d_ack_o(mem_d_ack_o), .mem_d_error_o(mem_d_error_o),
        .mem_d_data_rd_o(mem_d_data_rd_o), .mem_d_resp_tag_o(mem_d_resp_tag_o),
        .ram_en_o(ram_en_o), .ram_wr_o(ram_wr_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    // Single-ported SRAM, read-before-write, data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (ram_en_o) begin
            for (int b = 0; b < 4; b++)
                if (ram_wr_o[b]) sram[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
            ram_rdata_i <= sram[ram_addr_o];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        mem_i_rd_i = 0; mem_i_flush_i = 0; mem_i_invalidate_i = 0; mem_i_pc_i = 0;
        mem_d_addr_i = 0; mem_d_data_wr_i = 0; mem_d_rd_i = 0; mem_d_wr_i = 0;
        mem_d_cacheable_i = 0; mem_d_req_tag_i = 0;
        mem_d_invalidate_i = 0; mem_d_writeback_i = 0; mem_d_flush_i = 0;
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) sram[i] = 32'h0;
        sram[0]     = 32'h0000_1111;
        sram[4]     = 32'hCAFE_0010;
        sram[14'h40] = 32'h1122_3344;
        ram_rdata_i = 32'h0;

        // Reset with requests present: nothing may be accepted.
        rst = 1; idle();
        mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_0000;
        mem_d_rd_i = 1; mem_d_addr_i = 32'h8000_0010;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_i_accept", 32'(mem_i_accept_o), 0);
        chk("rst_d_accept", 32'(mem_d_accept_o), 0);
        chk("rst_ram_en",   32'(ram_en_o), 0);
        chk("rst_i_valid",  32'(mem_i_valid_o), 0);
        chk("rst_d_ack",    32'(mem_d_ack_o), 0);
        chk("rst_tag",      32'(mem_d_resp_tag_o), 0);
        chk("rst_starve",   32'(u_dut.starve_q), 0);

        @(negedge clk); rst = 0; idle();

        // Simultaneous fetch and load: data wins.
        @(negedge clk);
        mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_0000;
        mem_d_rd_i = 1; mem_d_addr_i = 32'h8000_0010; mem_d_req_tag_i = 11'h05A;
        #1;
        chk("sim_d_accept", 32'(mem_d_accept_o), 1);
        chk("sim_i_accept", 32'(mem_i_accept_o), 0);
        chk("sim_ram_en",   32'(ram_en_o), 1);
        chk("sim_ram_addr", 32'(ram_addr_o), 4);
        @(posedge clk); #1;
        chk("sim_ack",      32'(mem_d_ack_o), 1);
        chk("sim_rdata",    mem_d_data_rd_o, 32'hCAFE_0010);
        chk("sim_tag",      32'(mem_d_resp_tag_o), 32'h05A);
        chk("sim_i_valid",  32'(mem_i_valid_o), 0);
        @(negedge clk); idle();

        // Starvation: fetch forced through on the fifth contended cycle.
        @(negedge clk);
        mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_0000;
        mem_d_rd_i = 1; mem_d_addr_i = 32'h8000_0010; mem_d_req_tag_i = 11'h001;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("starve_i_acc_%0d", k), 32'(mem_i_accept_o), (k == 4) ? 1 : 0);
            chk($sformatf("starve_d_acc_%0d", k), 32'(mem_d_accept_o), (k == 4) ? 0 : 1);
        end
        chk("starve_ram_wr", 32'(ram_wr_o), 0);
        @(posedge clk); #1;
        chk("starve_i_valid", 32'(mem_i_valid_o), 1);
        chk("starve_inst",    mem_i_inst_o, 32'h0000_1111);
        chk("starve_d_ack",   32'(mem_d_ack_o), 0);
        @(negedge clk); #1;
        chk("starve_cleared_d_acc", 32'(mem_d_accept_o), 1);
        @(negedge clk); idle();

        // Store with partial byte enables, then read back.
        mem_d_addr_i = 32'h8000_0100; mem_d_wr_i = 4'b0011;
        mem_d_data_wr_i = 32'hDEAD_BEEF; mem_d_req_tag_i = 11'h011;
        #1;
        chk("st_accept",   32'(mem_d_accept_o), 1);
        chk("st_ram_wr",   32'(ram_wr_o), 32'h3);
        chk("st_ram_addr", 32'(ram_addr_o), 32'h40);
        chk("st_wdata",    ram_wdata_o, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("st_ack",      32'(mem_d_ack_o), 1);
        chk("st_rdata",    mem_d_data_rd_o, 0);
        chk("st_tag",      32'(mem_d_resp_tag_o), 32'h011);
        @(negedge clk);
        mem_d_wr_i = 4'b0000; mem_d_data_wr_i = 0; mem_d_rd_i = 1; mem_d_req_tag_i = 11'h012;
        @(posedge clk); #1;
        chk("ld_ack",      32'(mem_d_ack_o), 1);
        chk("ld_rdata",    mem_d_data_rd_o, 32'h1122_BEEF);
        chk("ld_tag",      32'(mem_d_resp_tag_o), 32'h012);
        @(negedge clk); idle();

        // Data flush: slot used, no SRAM access, ack with zero data.
        mem_d_flush_i = 1; mem_d_req_tag_i = 11'h7FF;
        #1;
        chk("mt_accept", 32'(mem_d_accept_o), 1);
        chk("mt_ram_en", 32'(ram_en_o), 0);
        @(posedge clk); #1;
        chk("mt_ack",    32'(mem_d_ack_o), 1);
        chk("mt_tag",    32'(mem_d_resp_tag_o), 32'h7FF);
        chk("mt_rdata",  mem_d_data_rd_o, 0);
        @(negedge clk); idle();

        // Fetch maintenance is ignored.
        mem_i_flush_i = 1; mem_i_invalidate_i = 1;
        #1;
        chk("if_accept", 32'(mem_i_accept_o), 0);
        chk("if_ram_en", 32'(ram_en_o), 0);
        @(posedge clk); #1;
        chk("if_valid",  32'(mem_i_valid_o), 0);
        @(negedge clk); idle();

        // Fetch outside the window.
        mem_i_rd_i = 1; mem_i_pc_i = 32'h0000_0000;
        #1;
        chk("rg_accept", 32'(mem_i_accept_o), 1);
`ifdef TCM_ARB_RANGE_CHK_EN
        chk("rg_ram_en", 32'(ram_en_o), 0);
        @(posedge clk); #1;
        chk("rg_valid",  32'(mem_i_valid_o), 1);
        chk("rg_err",    32'(mem_i_error_o), 1);
        chk("rg_inst",   mem_i_inst_o, 0);
`else
        chk("rg_ram_en",   32'(ram_en_o), 1);
        chk("rg_ram_addr", 32'(ram_addr_o), 0);
        @(posedge clk); #1;
        chk("rg_valid",  32'(mem_i_valid_o), 1);
        chk("rg_err",    32'(mem_i_error_o), 0);
        chk("rg_inst",   mem_i_inst_o, 32'h0000_1111);
`endif
        @(negedge clk); idle();

        // Reset while a load is in flight drops its response.
        mem_i_rd_i = 1; mem_i_pc_i = 32'h8000_0000;
        mem_d_rd_i = 1; mem_d_addr_i = 32'h8000_0010; mem_d_req_tag_i = 11'h033;
        #1;
        chk("rm_d_acc0", 32'(mem_d_accept_o), 1);
        @(posedge clk); #1;
        chk("rm_ack0",   32'(mem_d_ack_o), 1);
        chk("rm_starve1", 32'(u_dut.starve_q), 1);
        @(negedge clk); #1;
        chk("rm_d_acc1", 32'(mem_d_accept_o), 1);
        #2 rst = 1;
        #1;
        chk("rm_rst_d_acc",  32'(mem_d_accept_o), 0);
        chk("rm_rst_ram_en", 32'(ram_en_o), 0);
        @(posedge clk); #1;
        chk("rm_rst_ack",    32'(mem_d_ack_o), 0);
        chk("rm_rst_starve", 32'(u_dut.starve_q), 0);
        @(negedge clk); rst = 0; idle();
        @(posedge clk); #1;
        chk("rm_post_ack0",  32'(mem_d_ack_o), 0);
        @(posedge clk); #1;
        chk("rm_post_ack1",  32'(mem_d_ack_o), 0);
        chk("rm_post_ivld",  32'(mem_i_valid_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
